// File: rtl/viola_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Package : viola_pkg                                                      |
// | Shared types and constants for the dispatch path: bubble op code,        |
// | op-class enum, FSM state enum, held-instruction record and the default   |
// | ROB tag width.                                                           |
// | Revision: 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
package viola_pkg;

   localparam logic [4:0] NOP_OP        = 5'b11111;
   localparam int         DEF_ROB_TAG_W = 4;

   typedef enum logic [0:0] {
      CLS_ALU = 1'b0,
      CLS_MEM = 1'b1
   } op_cls_e;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } disp_state_e;

   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        has_imm;
   } instr_t;

endpackage
`default_nettype wire

// File: rtl/dispatch_scheduler_op_classifier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : op_classifier                                                  |
// | Combinational op-code to class mapping. Ops inside the inclusive range   |
// | [MEM_OP_LO, MEM_OP_HI] are memory ops; everything else is ALU.           |
// | Ports   : op_i  - 5-bit op code                                          |
// |           cls_o - resulting class (CLS_ALU / CLS_MEM)                    |
// | Revision: 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module op_classifier
   import viola_pkg::*;
#(
   parameter logic [4:0] MEM_OP_LO = 5'd16,
   parameter logic [4:0] MEM_OP_HI = 5'd23
) (
   input  logic [4:0] op_i,
   output op_cls_e    cls_o
);

   always_comb begin
      cls_o = CLS_ALU;
      if ((op_i >= MEM_OP_LO) && (op_i <= MEM_OP_HI)) begin
         cls_o = CLS_MEM;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dispatch_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : dispatch_scheduler                                             |
// | Pops one decoded instruction at a time from the IQ head into a single    |
// | hold register, then issues it to the ALU RS or LSB together with a ROB   |
// | allocation once the ROB and the target station both have room.          |
// | Blocked cycles are counted in a saturating counter.                      |
// | Ports   : clk, rst          - clock, synchronous active-high reset       |
// |           flush_i           - drop held instruction, block IQ pop        |
// |           iq_*_i / iq_pop_o - IQ head entry and accept strobe            |
// |           rob_*             - ROB full, next tag, allocation pulse       |
// |           alu_rs_full_i, lsb_full_i - station backpressure               |
// |           alu/lsb_issue_o, is_*_o  - registered issue pulses and bus     |
// |           stall_cycles_o    - saturating stall counter                   |
// | Revision: 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module dispatch_scheduler
   import viola_pkg::*;
#(
   parameter int         ROB_TAG_W   = DEF_ROB_TAG_W,
   parameter logic [4:0] MEM_OP_LO   = 5'd16,
   parameter logic [4:0] MEM_OP_HI   = 5'd23,
   parameter int         STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   iq_valid_i,
   input  logic [4:0]             iq_op_i,
   input  logic [4:0]             iq_rs1_i,
   input  logic [4:0]             iq_rs2_i,
   input  logic [4:0]             iq_rd_i,
   input  logic [31:0]            iq_imm_i,
   input  logic                   iq_has_imm_i,
   output logic                   iq_pop_o,
   input  logic                   rob_full_i,
   input  logic [ROB_TAG_W-1:0]   rob_tail_tag_i,
   output logic                   rob_alloc_o,
   input  logic                   alu_rs_full_i,
   input  logic                   lsb_full_i,
   output logic                   alu_issue_o,
   output logic                   lsb_issue_o,
   output logic [4:0]             is_op_o,
   output logic [4:0]             is_rs1_o,
   output logic [4:0]             is_rs2_o,
   output logic [4:0]             is_rd_o,
   output logic [31:0]            is_imm_o,
   output logic                   is_has_imm_o,
   output logic [ROB_TAG_W-1:0]   is_tag_o,
   output logic [STALL_CNT_W-1:0] stall_cycles_o
);

   disp_state_e            state_q,     state_d;
   instr_t                 hold_q,      hold_d;
   instr_t                 is_q,        is_d;
   logic [ROB_TAG_W-1:0]   is_tag_q,    is_tag_d;
   logic                   alu_issue_q, alu_issue_d;
   logic                   lsb_issue_q, lsb_issue_d;
   logic                   rob_alloc_q, rob_alloc_d;
   logic [STALL_CNT_W-1:0] stall_q,     stall_d;

   op_cls_e w_cls;
   logic    w_target_full;
   logic    w_go;
   logic    w_stall;
   logic    w_capture;

   op_classifier #(
      .MEM_OP_LO (MEM_OP_LO),
      .MEM_OP_HI (MEM_OP_HI)
   ) u_op_classifier (
      .op_i  (hold_q.op),
      .cls_o (w_cls)
   );

   assign w_target_full = (w_cls == CLS_MEM) ? lsb_full_i : alu_rs_full_i;
   assign w_go          = (state_q == ST_HOLD) && !rob_full_i && !w_target_full && !flush_i;
   assign w_stall       = (state_q == ST_HOLD) && !w_go && !flush_i;
   // Popping while issuing keeps the hold register busy every cycle under a steady stream.
   assign iq_pop_o      = !flush_i && ((state_q == ST_EMPTY) || w_go);
   assign w_capture     = iq_valid_i && iq_pop_o;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      is_d        = is_q;
      is_d.op     = NOP_OP;
      is_tag_d    = is_tag_q;
      alu_issue_d = 1'b0;
      lsb_issue_d = 1'b0;
      rob_alloc_d = 1'b0;
      stall_d     = stall_q;

      if (w_go) begin
         rob_alloc_d = 1'b1;
         alu_issue_d = (w_cls == CLS_ALU);
         lsb_issue_d = (w_cls == CLS_MEM);
         is_d        = hold_q;
         is_tag_d    = rob_tail_tag_i;
         state_d     = ST_EMPTY;
      end

      if (w_stall && (stall_q != {STALL_CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end

      // A popped bubble is simply not loaded, so the state falls out as EMPTY.
      if (w_capture && (iq_op_i != NOP_OP)) begin
         hold_d.op      = iq_op_i;
         hold_d.rs1     = iq_rs1_i;
         hold_d.rs2     = iq_rs2_i;
         hold_d.rd      = iq_rd_i;
         hold_d.imm     = iq_imm_i;
         hold_d.has_imm = iq_has_imm_i;
         state_d        = ST_HOLD;
      end

      if (flush_i) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         hold_q      <= '0;
         is_q        <= '0;
         is_q.op     <= NOP_OP;
         is_tag_q    <= '0;
         alu_issue_q <= 1'b0;
         lsb_issue_q <= 1'b0;
         rob_alloc_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         is_q        <= is_d;
         is_tag_q    <= is_tag_d;
         alu_issue_q <= alu_issue_d;
         lsb_issue_q <= lsb_issue_d;
         rob_alloc_q <= rob_alloc_d;
         stall_q     <= stall_d;
      end
   end

   assign alu_issue_o    = alu_issue_q;
   assign lsb_issue_o    = lsb_issue_q;
   assign rob_alloc_o    = rob_alloc_q;
   assign is_op_o        = is_q.op;
   assign is_rs1_o       = is_q.rs1;
   assign is_rs2_o       = is_q.rs2;
   assign is_rd_o        = is_q.rd;
   assign is_imm_o       = is_q.imm;
   assign is_has_imm_o   = is_q.has_imm;
   assign is_tag_o       = is_tag_q;
   assign stall_cycles_o = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : tb_dispatch_scheduler                                          |
// | Self-checking bench for dispatch_scheduler. Expected issues are queued   |
// | when an instruction is offered and matched against each issue pulse.     |
// | Revision: 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module tb_dispatch_scheduler;

   localparam logic [4:0] NOP = 5'b11111;

   typedef struct packed {
      logic        is_mem;
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        has_imm;
      logic [3:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        iq_valid = 1'b0;
   logic [4:0]  iq_op = 5'd0, iq_rs1 = 5'd0, iq_rs2 = 5'd0, iq_rd = 5'd0;
   logic [31:0] iq_imm = 32'd0;
   logic        iq_has_imm = 1'b0;
   logic        iq_pop;
   logic        rob_full = 1'b0;
   logic [3:0]  rob_tail_tag = 4'd0;
   logic        rob_alloc;
   logic        alu_rs_full = 1'b0, lsb_full = 1'b0;
   logic        alu_issue, lsb_issue;
   logic [4:0]  is_op, is_rs1, is_rs2, is_rd;
   logic [31:0] is_imm;
   logic        is_has_imm;
   logic [3:0]  is_tag;
   logic [3:0]  stall_cycles;

   int   checks = 0;
   int   errors = 0;
   int   alu_cnt = 0;
   int   lsb_cnt = 0;
   bit   started = 1'b0;
   exp_t exp_q[$];
   exp_t e;

   always #5 clk = ~clk;

   dispatch_scheduler #(
      .ROB_TAG_W   (4),
      .MEM_OP_LO   (5'd16),
      .MEM_OP_HI   (5'd23),
      .STALL_CNT_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (flush),
      .iq_valid_i     (iq_valid),
      .iq_op_i        (iq_op),
      .iq_rs1_i       (iq_rs1),
      .iq_rs2_i       (iq_rs2),
      .iq_rd_i        (iq_rd),
      .iq_imm_i       (iq_imm),
      .iq_has_imm_i   (iq_has_imm),
      .iq_pop_o       (iq_pop),
      .rob_full_i     (rob_full),
      .rob_tail_tag_i (rob_tail_tag),
      .rob_alloc_o    (rob_alloc),
      .alu_rs_full_i  (alu_rs_full),
      .lsb_full_i     (lsb_full),
      .alu_issue_o    (alu_issue),
      .lsb_issue_o    (lsb_issue),
      .is_op_o        (is_op),
      .is_rs1_o       (is_rs1),
      .is_rs2_o       (is_rs2),
      .is_rd_o        (is_rd),
      .is_imm_o       (is_imm),
      .is_has_imm_o   (is_has_imm),
      .is_tag_o       (is_tag),
      .stall_cycles_o (stall_cycles)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Operand fields are derived from op and rd so each beat is distinguishable.
   task automatic drive(input logic [4:0] op, input logic [4:0] rd);
      iq_valid   = 1'b1;
      iq_op      = op;
      iq_rd      = rd;
      iq_rs1     = op ^ 5'd7;
      iq_rs2     = rd ^ 5'd9;
      iq_imm     = 32'hA500_0000 | {22'd0, op, rd};
      iq_has_imm = op[0];
   endtask

   task automatic expect_issue(input logic [4:0] op, input logic [4:0] rd, input logic [3:0] tag);
      exp_t x;
      x.is_mem  = (op >= 5'd16) && (op <= 5'd23);
      x.op      = op;
      x.rd      = rd;
      x.rs1     = op ^ 5'd7;
      x.rs2     = rd ^ 5'd9;
      x.imm     = 32'hA500_0000 | {22'd0, op, rd};
      x.has_imm = op[0];
      x.tag     = tag;
      exp_q.push_back(x);
   endtask

   // Scoreboard: every issue pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (alu_issue === 1'b1 || lsb_issue === 1'b1) begin
            if (alu_issue === 1'b1) alu_cnt++;
            if (lsb_issue === 1'b1) lsb_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue: got op=%0d alu=%b lsb=%b, required no issue", is_op, alu_issue, lsb_issue);
            end else begin
               e = exp_q.pop_front();
               if ({lsb_issue, alu_issue, rob_alloc, is_op, is_rs1, is_rs2, is_rd, is_imm, is_has_imm, is_tag} !==
                   {e.is_mem, ~e.is_mem, 1'b1, e.op, e.rs1, e.rs2, e.rd, e.imm, e.has_imm, e.tag}) begin
                  errors++;
                  $display("FAIL issue_fields: got lsb=%b alu=%b alloc=%b op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h hi=%b tag=%0d, required lsb=%b op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h hi=%b tag=%0d",
                           lsb_issue, alu_issue, rob_alloc, is_op, is_rs1, is_rs2, is_rd, is_imm, is_has_imm, is_tag,
                           e.is_mem, e.op, e.rs1, e.rs2, e.rd, e.imm, e.has_imm, e.tag);
               end
            end
         end else if (rob_alloc !== 1'b0 || is_op !== NOP) begin
            errors++;
            $display("FAIL idle_outputs: got alloc=%b is_op=%0d, required alloc=0 is_op=31", rob_alloc, is_op);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      started = 1'b1;
      checks++;
      if ({alu_issue, lsb_issue, rob_alloc, is_op, stall_cycles} !== {3'b000, NOP, 4'd0}) begin
         errors++;
         $display("FAIL reset_state: got alu=%b lsb=%b alloc=%b is_op=%0d stall=%0d, required 0 0 0 31 0",
                  alu_issue, lsb_issue, rob_alloc, is_op, stall_cycles);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (iq_pop !== 1'b1) begin
         errors++;
         $display("FAIL reset_pop: got iq_pop=%b, required 1", iq_pop);
      end
   endtask

   task automatic test_single_alu();
      int a0 = alu_cnt;
      rob_tail_tag = 4'd7;
      drive(5'd1, 5'd3);
      #1;
      checks++;
      if (iq_pop !== 1'b1) begin
         errors++;
         $display("FAIL single_pop: got iq_pop=%b, required 1", iq_pop);
      end
      expect_issue(5'd1, 5'd3, 4'd7);
      tick();                       // E0: accept
      iq_valid = 1'b0;
      checks++;
      if (alu_issue !== 1'b0) begin
         errors++;
         $display("FAIL single_early: got alu_issue=%b after E0, required 0", alu_issue);
      end
      tick();                       // E1: issue
      checks++;
      if ({alu_issue, rob_alloc, is_rd, is_tag} !== {2'b11, 5'd3, 4'd7}) begin
         errors++;
         $display("FAIL single_issue: got alu=%b alloc=%b rd=%0d tag=%0d, required 1 1 3 7", alu_issue, rob_alloc, is_rd, is_tag);
      end
      tick();
      checks++;
      if ({alu_issue, is_op, is_rd, alu_cnt} !== {1'b0, NOP, 5'd3, a0 + 1}) begin
         errors++;
         $display("FAIL single_after: got alu=%b is_op=%0d rd=%0d pulses=%0d, required 0 31 3 %0d", alu_issue, is_op, is_rd, alu_cnt - a0, 1);
      end
   endtask

   task automatic test_stall_mem();
      int l0 = lsb_cnt;
      logic [3:0] s0 = stall_cycles;
      lsb_full = 1'b1;
      rob_tail_tag = 4'd9;
      drive(5'd16, 5'd5);
      expect_issue(5'd16, 5'd5, 4'd9);
      tick();                       // accepted
      drive(5'd2, 5'd6);            // next IQ entry waits, must not be popped
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (iq_pop !== 1'b0) begin
            errors++;
            $display("FAIL stall_pop: cycle %0d got iq_pop=%b, required 0", k, iq_pop);
         end
         tick();
      end
      checks++;
      if (stall_cycles !== s0 + 4'd5 || lsb_cnt != l0) begin
         errors++;
         $display("FAIL stall_count: got stall=%0d lsb_pulses=%0d, required %0d 0", stall_cycles, lsb_cnt - l0, s0 + 4'd5);
      end
      iq_valid = 1'b0;
      lsb_full = 1'b0;
      tick();
      tick();
      checks++;
      if (stall_cycles !== s0 + 4'd5 || lsb_cnt != l0 + 1) begin
         errors++;
         $display("FAIL stall_release: got stall=%0d lsb_pulses=%0d, required %0d 1", stall_cycles, lsb_cnt - l0, s0 + 4'd5);
      end
   endtask

   task automatic test_back_to_back();
      int a0 = alu_cnt;
      for (int k = 0; k < 4; k++) begin
         rob_tail_tag = 4'(10 + k);
         drive(5'(k + 2), 5'(k + 20));
         #1;
         checks++;
         if (iq_pop !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop: beat %0d got iq_pop=%b, required 1", k, iq_pop);
         end
         // Issue happens on the following edge, which samples the next tag.
         expect_issue(5'(k + 2), 5'(k + 20), 4'(11 + k));
         tick();
         if (k > 0) begin
            checks++;
            if (alu_issue !== 1'b1) begin
               errors++;
               $display("FAIL b2b_bubble: after beat %0d got alu_issue=%b, required 1", k, alu_issue);
            end
         end
      end
      iq_valid = 1'b0;
      rob_tail_tag = 4'd14;
      tick();
      checks++;
      if (alu_issue !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last: got alu_issue=%b, required 1", alu_issue);
      end
      tick();
      checks++;
      if (alu_cnt != a0 + 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses, required 4", alu_cnt - a0);
      end
   endtask

   task automatic test_flush();
      int l0 = lsb_cnt;
      int a0 = alu_cnt;
      logic [3:0] s0;
      rob_full = 1'b1;
      rob_tail_tag = 4'd3;
      drive(5'd20, 5'd8);
      tick();                       // MEM op held
      iq_valid = 1'b0;
      tick();                       // one stall edge
      s0 = stall_cycles;
      flush = 1'b1;
      drive(5'd5, 5'd9);
      #1;
      checks++;
      if (iq_pop !== 1'b0) begin
         errors++;
         $display("FAIL flush_pop: got iq_pop=%b, required 0", iq_pop);
      end
      tick();
      flush = 1'b0;
      checks++;
      if ({alu_issue, lsb_issue, rob_alloc, stall_cycles} !== {3'b000, s0}) begin
         errors++;
         $display("FAIL flush_edge: got alu=%b lsb=%b alloc=%b stall=%0d, required 0 0 0 %0d", alu_issue, lsb_issue, rob_alloc, stall_cycles, s0);
      end
      rob_full = 1'b0;
      rob_tail_tag = 4'd12;
      #1;
      checks++;
      if (iq_pop !== 1'b1) begin
         errors++;
         $display("FAIL flush_empty: got iq_pop=%b, required 1", iq_pop);
      end
      expect_issue(5'd5, 5'd9, 4'd12);
      tick();
      iq_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (lsb_cnt != l0 || alu_cnt != a0 + 1) begin
         errors++;
         $display("FAIL flush_result: got lsb=%0d alu=%0d pulses, required 0 1", lsb_cnt - l0, alu_cnt - a0);
      end
   endtask

   task automatic test_nop();
      logic [3:0] s0 = stall_cycles;
      int a0 = alu_cnt;
      int l0 = lsb_cnt;
      drive(NOP, 5'd4);
      #1;
      checks++;
      if (iq_pop !== 1'b1) begin
         errors++;
         $display("FAIL nop_pop: got iq_pop=%b, required 1", iq_pop);
      end
      tick();
      iq_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (alu_cnt != a0 || lsb_cnt != l0 || rob_alloc !== 1'b0 || stall_cycles !== s0 || iq_pop !== 1'b1) begin
         errors++;
         $display("FAIL nop_dropped: got pulses=%0d alloc=%b stall=%0d pop=%b, required 0 0 %0d 1",
                  alu_cnt - a0 + lsb_cnt - l0, rob_alloc, stall_cycles, s0, iq_pop);
      end
   endtask

   task automatic test_saturate();
      logic [4:0] expv;
      logic [3:0] s0 = stall_cycles;
      int a0 = alu_cnt;
      alu_rs_full = 1'b1;
      rob_full = 1'b1;              // both blocked: still one count per cycle
      drive(5'd3, 5'd1);
      tick();
      iq_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         expv = ({1'b0, s0} + 5'(k) > 5'd15) ? 5'd15 : {1'b0, s0} + 5'(k);
         checks++;
         if ({1'b0, stall_cycles} !== expv) begin
            errors++;
            $display("FAIL stall_sat: cycle %0d got %0d, required %0d", k, stall_cycles, expv);
         end
      end
      rst = 1'b1;
      tick();
      checks++;
      if (stall_cycles !== 4'd0 || alu_issue !== 1'b0) begin
         errors++;
         $display("FAIL sat_reset: got stall=%0d alu=%b, required 0 0", stall_cycles, alu_issue);
      end
      rst = 1'b0;
      alu_rs_full = 1'b0;
      rob_full = 1'b0;
      tick();
      tick();
      checks++;
      if (alu_cnt != a0 || iq_pop !== 1'b1) begin
         errors++;
         $display("FAIL rst_discard: got pulses=%0d pop=%b, required 0 1", alu_cnt - a0, iq_pop);
      end
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_stall_mem();
      test_back_to_back();
      test_flush();
      test_nop();
      test_saturate();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_issues: got %0d never issued, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
